// File: rtl/sweep_pkg.sv
// Shared types and constants for the frequency-sweep sequencer.
package sweep_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sweep_state_t;

   localparam logic MODE_ONESHOT = 1'b0;
   localparam logic MODE_BOUNCE  = 1'b1;

endpackage

// File: rtl/sweep_ctrl_if.sv
// Control/config inputs and counter-drive outputs of the sweep sequencer.
interface sweep_ctrl_if #(
   parameter int WIDTH   = 8,
   parameter int DWELL_W = 16
);
   logic               start;
   logic               stop;
   logic               mode;
   logic [WIDTH-1:0]   start_incr;
   logic [WIDTH-1:0]   end_incr;
   logic [WIDTH-1:0]   step;
   logic [DWELL_W-1:0] dwell;
   logic [WIDTH-1:0]   incr;
   logic               en;
   logic               busy;
   logic               done;

   modport master (
      output start, stop, mode, start_incr, end_incr, step, dwell,
      input  incr, en, busy, done
   );

   modport slave (
      input  start, stop, mode, start_incr, end_incr, step, dwell,
      output incr, en, busy, done
   );
endinterface

// File: rtl/sweep_ctrl_dwell_timer.sv
// Free-running dwell counter: expire marks the last cycle of every
// D-cycle period, D = max(dwell,1). load restarts the period.
module dwell_timer #(
   parameter int DWELL_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [DWELL_W-1:0] dwell,
   output logic               expire
);

   logic [DWELL_W-1:0] cnt_q;
   logic [DWELL_W-1:0] reload;

   // Period minus one; dwell of zero behaves as a one-cycle period.
   always_comb begin
      reload = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
   end

   // Count down to zero, then wrap to the reload value.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (load || (cnt_q == '0)) begin
         cnt_q <= reload;
      end else begin
         cnt_q <= cnt_q - DWELL_W'(1);
      end
   end

   assign expire = (cnt_q == '0);

endmodule

// File: rtl/sweep_ctrl.sv
// Frequency-sweep sequencer: steps the phase-counter increment from a
// start value to an end value (one-shot) or back and forth (bounce).
module sweep_ctrl
   import sweep_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int DWELL_W = 16
) (
   input  logic       clk,
   input  logic       rst,
   sweep_ctrl_if.slave bus
);

   sweep_state_t       state_q, state_nxt;

   logic [WIDTH-1:0]   incr_q, incr_nxt;
   logic               dir_q, dir_nxt;
   logic               en_q, busy_q, done_q;
   logic               en_nxt, busy_nxt, done_nxt;

   logic               mode_q;
   logic [WIDTH-1:0]   start_q, end_q, step_q;
   logic [DWELL_W-1:0] dwell_q;

   logic               cfg_load;
   logic [DWELL_W-1:0] timer_dwell;
   logic               expire;

   logic               up_base;
   logic [WIDTH-1:0]   target;

   // Move cur by stp toward tgt in WIDTH+1 bits; never pass tgt, never wrap.
   function automatic logic [WIDTH-1:0] clamp_step(
      input logic [WIDTH-1:0] cur,
      input logic [WIDTH-1:0] tgt,
      input logic [WIDTH-1:0] stp,
      input logic             up
   );
      logic [WIDTH:0] ext;
      logic [WIDTH-1:0] res;
      if (up) begin
         ext = {1'b0, cur} + {1'b0, stp};
         res = (ext >= {1'b0, tgt}) ? tgt : ext[WIDTH-1:0];
      end else begin
         ext = {1'b0, cur} - {1'b0, stp};
         res = (ext[WIDTH] || (ext <= {1'b0, tgt})) ? tgt : ext[WIDTH-1:0];
      end
      return res;
   endfunction

   assign cfg_load    = (state_q == IDLE) && bus.start && !bus.stop;
   // The timer must see the incoming dwell on the start edge, the latched one after.
   assign timer_dwell = (state_q == IDLE) ? bus.dwell : dwell_q;
   assign up_base     = (end_q >= start_q);
   assign target      = dir_q ? start_q : end_q;

   dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (cfg_load),
      .dwell  (timer_dwell),
      .expire (expire)
   );

   // Capture the sweep configuration on an accepted start; held while busy.
   always_ff @(posedge clk) begin
      if (cfg_load) begin
         mode_q  <= bus.mode;
         start_q <= bus.start_incr;
         end_q   <= bus.end_incr;
         step_q  <= (bus.step == '0) ? WIDTH'(1) : bus.step;
         dwell_q <= bus.dwell;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Next state, next increment and next direction.
   always_comb begin
      state_nxt = state_q;
      incr_nxt  = incr_q;
      dir_nxt   = dir_q;
      unique case (state_q)
         IDLE: begin
            incr_nxt = '0;
            dir_nxt  = 1'b0;
            if (cfg_load) begin
               state_nxt = RUN;
               incr_nxt  = bus.start_incr;
            end
         end
         RUN: begin
            if (bus.stop) begin
               state_nxt = IDLE;
               incr_nxt  = '0;
               dir_nxt   = 1'b0;
            end else if (expire) begin
               if (incr_q != target) begin
                  incr_nxt = clamp_step(incr_q, target, step_q, up_base ^ dir_q);
               end else if (mode_q == MODE_ONESHOT) begin
                  state_nxt = DONE;
               end else begin
                  // Turn around at the endpoint and take the first step back at once.
                  dir_nxt  = ~dir_q;
                  incr_nxt = clamp_step(incr_q, dir_q ? end_q : start_q, step_q,
                                        up_base ^ ~dir_q);
               end
            end
         end
         DONE: begin
            state_nxt = IDLE;
            incr_nxt  = '0;
            dir_nxt   = 1'b0;
         end
         default: begin
            state_nxt = IDLE;
            incr_nxt  = '0;
            dir_nxt   = 1'b0;
         end
      endcase
   end

   // Output values for the coming cycle, decoded from the next state.
   always_comb begin
      en_nxt   = (state_nxt == RUN);
      busy_nxt = (state_nxt != IDLE);
      done_nxt = (state_nxt == DONE);
   end

   // Registered outputs, direction and current increment.
   always_ff @(posedge clk) begin
      if (!rst) begin
         incr_q <= '0;
         dir_q  <= 1'b0;
         en_q   <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         incr_q <= incr_nxt;
         dir_q  <= dir_nxt;
         en_q   <= en_nxt;
         busy_q <= busy_nxt;
         done_q <= done_nxt;
      end
   end

   assign bus.incr = incr_q;
   assign bus.en   = en_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Directed bench for sweep_ctrl: one task per scenario, inline checks.
module tb_sweep_ctrl;

   localparam int WIDTH   = 8;
   localparam int DWELL_W = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   sweep_ctrl_if #(.WIDTH(WIDTH), .DWELL_W(DWELL_W)) bus ();

   sweep_ctrl #(.WIDTH(WIDTH), .DWELL_W(DWELL_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic m, input int s, input int e, input int st, input int dw);
      bus.mode       = m;
      bus.start_incr = WIDTH'(s);
      bus.end_incr   = WIDTH'(e);
      bus.step       = WIDTH'(st);
      bus.dwell      = DWELL_W'(dw);
   endtask

   task automatic test_reset();
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      cfg(1'b0, 0, 0, 0, 0);
      rst = 1'b0;
      tick();
      tick();
      total++;
      if (bus.incr !== 8'd0 || bus.en !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         bad++;
         $display("FAIL reset: incr=%0d en=%b busy=%b done=%b, want 0 0 0 0",
                  bus.incr, bus.en, bus.busy, bus.done);
      end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_oneshot_up();
      int exp_seq[6] = '{4, 4, 7, 7, 10, 10};
      cfg(1'b0, 4, 10, 3, 2);
      bus.start = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         bus.start = 1'b0;
         total++;
         if (bus.incr !== 8'(exp_seq[i]) || bus.en !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL oneshot_up[%0d]: incr=%0d en=%b busy=%b done=%b, want %0d 1 1 0",
                     i, bus.incr, bus.en, bus.busy, bus.done, exp_seq[i]);
         end
      end
      tick();
      total++;
      if (bus.done !== 1'b1 || bus.en !== 1'b0 || bus.busy !== 1'b1 || bus.incr !== 8'd10) begin
         bad++;
         $display("FAIL oneshot_up done: done=%b en=%b busy=%b incr=%0d, want 1 0 1 10",
                  bus.done, bus.en, bus.busy, bus.incr);
      end
      tick();
      total++;
      if (bus.done !== 1'b0 || bus.en !== 1'b0 || bus.busy !== 1'b0 || bus.incr !== 8'd0) begin
         bad++;
         $display("FAIL oneshot_up idle: done=%b en=%b busy=%b incr=%0d, want 0 0 0 0",
                  bus.done, bus.en, bus.busy, bus.incr);
      end
   endtask

   task automatic test_descend_clamp();
      int exp_seq[4] = '{200, 196, 192, 190};
      cfg(1'b0, 200, 190, 4, 1);
      bus.start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         bus.start = 1'b0;
         total++;
         if (bus.incr !== 8'(exp_seq[i]) || bus.en !== 1'b1) begin
            bad++;
            $display("FAIL descend[%0d]: incr=%0d en=%b, want %0d 1", i, bus.incr, bus.en, exp_seq[i]);
         end
      end
      tick();
      total++;
      if (bus.done !== 1'b1 || bus.en !== 1'b0 || bus.incr !== 8'd190) begin
         bad++;
         $display("FAIL descend done: done=%b en=%b incr=%0d, want 1 0 190", bus.done, bus.en, bus.incr);
      end
      tick();
   endtask

   task automatic test_overflow_clamp();
      int exp_seq[2] = '{250, 255};
      cfg(1'b0, 250, 255, 10, 1);
      bus.start = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         bus.start = 1'b0;
         total++;
         if (bus.incr !== 8'(exp_seq[i]) || bus.en !== 1'b1) begin
            bad++;
            $display("FAIL overflow[%0d]: incr=%0d en=%b, want %0d 1", i, bus.incr, bus.en, exp_seq[i]);
         end
      end
      tick();
      total++;
      if (bus.done !== 1'b1 || bus.en !== 1'b0 || bus.incr !== 8'd255) begin
         bad++;
         $display("FAIL overflow done: done=%b en=%b incr=%0d, want 1 0 255", bus.done, bus.en, bus.incr);
      end
      tick();
   endtask

   task automatic test_bounce();
      int pat[4] = '{2, 4, 6, 4};
      cfg(1'b1, 2, 6, 2, 1);
      bus.start = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         bus.start = 1'b0;
         total++;
         if (bus.incr !== 8'(pat[i % 4]) || bus.en !== 1'b1 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL bounce[%0d]: incr=%0d en=%b done=%b, want %0d 1 0",
                     i, bus.incr, bus.en, bus.done, pat[i % 4]);
         end
      end
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      total++;
      if (bus.en !== 1'b0 || bus.incr !== 8'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         bad++;
         $display("FAIL bounce stop: en=%b incr=%0d busy=%b done=%b, want 0 0 0 0",
                  bus.en, bus.incr, bus.busy, bus.done);
      end
      tick();
   endtask

   task automatic test_start_stop_idle();
      cfg(1'b0, 4, 10, 3, 1);
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      tick();
      tick();
      total++;
      if (bus.busy !== 1'b0 || bus.en !== 1'b0 || bus.incr !== 8'd0) begin
         bad++;
         $display("FAIL start_stop_idle: busy=%b en=%b incr=%0d, want 0 0 0", bus.busy, bus.en, bus.incr);
      end
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      tick();
   endtask

   task automatic test_midrun_changes();
      int exp_seq[6] = '{4, 4, 7, 7, 10, 10};
      cfg(1'b0, 4, 10, 3, 2);
      bus.start = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i == 0) begin
            bus.start = 1'b0;
         end else begin
            // Re-pulse start and scramble the config while running.
            bus.start = 1'b1;
            cfg(1'b1, 100, 50, 1, 5);
         end
         total++;
         if (bus.incr !== 8'(exp_seq[i]) || bus.en !== 1'b1) begin
            bad++;
            $display("FAIL midrun[%0d]: incr=%0d en=%b, want %0d 1", i, bus.incr, bus.en, exp_seq[i]);
         end
      end
      bus.start = 1'b0;
      tick();
      total++;
      if (bus.done !== 1'b1 || bus.en !== 1'b0 || bus.incr !== 8'd10) begin
         bad++;
         $display("FAIL midrun done: done=%b en=%b incr=%0d, want 1 0 10", bus.done, bus.en, bus.incr);
      end
      tick();
   endtask

   task automatic test_zero_dwell_step();
      int exp_seq[3] = '{1, 2, 3};
      cfg(1'b0, 1, 3, 0, 0);
      bus.start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         bus.start = 1'b0;
         total++;
         if (bus.incr !== 8'(exp_seq[i]) || bus.en !== 1'b1) begin
            bad++;
            $display("FAIL zero_dw_st[%0d]: incr=%0d en=%b, want %0d 1", i, bus.incr, bus.en, exp_seq[i]);
         end
      end
      tick();
      total++;
      if (bus.done !== 1'b1 || bus.en !== 1'b0) begin
         bad++;
         $display("FAIL zero_dw_st done: done=%b en=%b, want 1 0", bus.done, bus.en);
      end
      tick();
   endtask

   task automatic test_reset_midsweep();
      int exp_seq[3] = '{4, 7, 10};
      cfg(1'b1, 2, 6, 2, 1);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      total++;
      if (bus.incr !== 8'd0 || bus.en !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid: incr=%0d en=%b busy=%b done=%b, want 0 0 0 0",
                  bus.incr, bus.en, bus.busy, bus.done);
      end
      cfg(1'b0, 4, 10, 3, 1);
      bus.start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         bus.start = 1'b0;
         total++;
         if (bus.incr !== 8'(exp_seq[i]) || bus.en !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid fresh[%0d]: incr=%0d en=%b, want %0d 1", i, bus.incr, bus.en, exp_seq[i]);
         end
      end
      tick();
      total++;
      if (bus.done !== 1'b1 || bus.incr !== 8'd10) begin
         bad++;
         $display("FAIL reset_mid done: done=%b incr=%0d, want 1 10", bus.done, bus.incr);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_oneshot_up();
      test_descend_clamp();
      test_overflow_clamp();
      test_bounce();
      test_start_stop_idle();
      test_midrun_changes();
      test_zero_dwell_step();
      test_reset_midsweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sweep_ctrl.md
Name: sweep_ctrl

Overview:
- Frequency-sweep sequencer for the signal generator's phase counter.
- Drives the counter's `incr` and `en` inputs so the output frequency steps from a start increment to an end increment.
- Each value is held for a programmable dwell time, either once (one-shot) or bouncing between the endpoints (triangle sweep).
- Sits between top-level control inputs and the counter/sine-ROM datapath.

Parameters:
WIDTH, 8, width of increment values; matches the phase counter WIDTH.
DWELL_W, 16, width of the dwell-time field in clock cycles.

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous reset, active-low (reset when rst==0 at posedge)
start  input  1  begin sweep; sampled only in IDLE
stop  input  1  abort sweep; sampled in any state
mode  input  1  0 = one-shot, 1 = bounce (triangle, runs until stop)
start_incr  input  WIDTH  first increment value
end_incr  input  WIDTH  final/turnaround increment value
step  input  WIDTH  magnitude of change per dwell period
dwell  input  DWELL_W  cycles each value is held
incr  output  WIDTH  increment to the counter; registered
en  output  1  counter enable; registered
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse at the end of a one-shot sweep

Behaviour:
- Reset (rst==0): state IDLE, incr=0, en=0, busy=0, done=0, dwell count 0, direction bit 0. Reset overrides all inputs, including mid-sweep.
- States: IDLE, RUN, DONE; all outputs registered.
- IDLE: en=0, incr=0, busy=0.
  - start=1 and stop=0 at edge N: latch mode, start_incr, end_incr, step, dwell.
  - Cycle N+1: state RUN, incr=start_incr, en=1, busy=1.
- Config latching: inputs other than stop are ignored while busy, and later changes to them have no effect on a running sweep. start while busy is ignored.
- Edge-case inputs:
  - dwell==0 is treated as 1.
  - step==0 is treated as 1.
- Direction: up if end_incr >= start_incr, else down.
  - In bounce mode the direction flips at each endpoint.
  - The current target is end_incr when moving away from the start value, and start_incr when returning.
- RUN: each incr value is held for exactly D = max(dwell,1) cycles.
  - At the last cycle of a dwell, if incr != target: next incr = incr ± step, computed in WIDTH+1 bits and clamped to target. No wrap-around, and no overshoot past either endpoint.
  - If incr == target, one-shot: go to DONE (en=0, done=1, incr holds end value for that cycle).
  - If incr == target, bounce: flip direction and step toward the other endpoint in the same transition.
  - start_incr == end_incr:
    - one-shot: one dwell period, then DONE;
    - bounce: value held indefinitely.
- DONE: lasts exactly 1 cycle, then IDLE (incr=0, en=0, busy=0, done=0).
- stop=1 in RUN or DONE: next cycle IDLE with en=0, incr=0, no done pulse. start and stop both high in IDLE: stop wins, remain IDLE.
- Latency: start to first enabled cycle is 1 cycle; stop to en=0 is 1 cycle.

Decomposition:
- Package sweep_pkg:
  - state enum typedef sweep_state_t {IDLE, RUN, DONE};
  - constants MODE_ONESHOT=1'b0 and MODE_BOUNCE=1'b1.
- One sub-module: dwell_timer (parameter DWELL_W).
  - Inputs: clk, rst, load, dwell.
  - Output: expire, high on the last cycle of each D-cycle period.
  - Free-runs while enabled and reloads on load.
- Top-level sweep_ctrl holds the FSM, the direction bit and the clamped step arithmetic.

Test Plan:
- One-shot up: mode=0, start=4, end=10, step=3, dwell=2 -> incr 4,4,7,7,10,10 with en=1; next cycle done=1, en=0; then incr=0, busy=0.
- Descending with clamp: start=200, end=190, step=4, dwell=1 -> incr 200,196,192,190, then done pulse; never below 190.
- Overflow clamp: start=250, end=255, step=10, dwell=1 -> incr 250,255, then done; no wrap to 4.
- Bounce: mode=1, start=2, end=6, step=2, dwell=1 -> 2,4,6,4,2,4,6,… for 20 cycles with en=1, no done; assert stop -> next cycle en=0, incr=0.
- Control corners:
  - start+stop together in IDLE -> stays IDLE;
  - start pulsed mid-RUN -> sequence unchanged;
  - inputs changed mid-RUN -> sequence unchanged;
  - dwell=0, step=0 with start=1, end=3 -> 1,2,3, done.
- Reset mid-sweep: rst=0 for one cycle during RUN -> next cycle incr=0, en=0, busy=0, done=0; a new start then runs a fresh sequence.
